// File: rtl/seq_pkg.sv
// Shared types and constants for the serializer / sequence-detector slice.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } ser_state_t;

    localparam int   SER_WIDTH  = 8;
    localparam logic RST_ACTIVE = 1'b0;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: takes WIDTH-bit words over valid/ready and emits
// one registered bit per clock with bit_valid and a word_done pulse on the last bit.
module bit_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH     = SER_WIDTH,
    parameter int MSB_FIRST = 1,
    parameter int IDLE_GAP  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             data_out,
    output logic             bit_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GAP_W = (IDLE_GAP > 0) ? $clog2(IDLE_GAP + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IDLE_GAP - 1);
    localparam logic BACK_TO_BACK = (IDLE_GAP == 0) ? 1'b1 : 1'b0;
    localparam logic SEND_MSB     = (MSB_FIRST != 0) ? 1'b1 : 1'b0;

    ser_state_t       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [GAP_W-1:0] gap_q,   gap_d;
    logic             data_q,  data_d;
    logic             valid_q, valid_d;
    logic             done_q,  done_d;
    logic             xfer_s;
    logic             load_s;

    // Handshake ready: IDLE, or the last bit of a word when words may abut.
    always_comb begin
        in_ready = 1'b0;
        if (rst == RST_ACTIVE) begin
            in_ready = 1'b0;
        end else if (state_q == IDLE) begin
            in_ready = 1'b1;
        end else if ((state_q == SHIFT) && (cnt_q == LAST_CNT)) begin
            in_ready = BACK_TO_BACK;
        end else begin
            in_ready = 1'b0;
        end
    end

    assign xfer_s = in_valid && in_ready;

    // Next-state logic for the FSM and the shift/count datapath.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        data_d  = 1'b0;
        valid_d = 1'b0;
        done_d  = 1'b0;
        load_s  = 1'b0;
        case (state_q)
            IDLE: begin
                load_s = xfer_s;
            end
            SHIFT: begin
                if (cnt_q != LAST_CNT) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    valid_d = 1'b1;
                    done_d  = (cnt_d == LAST_CNT);
                    if (SEND_MSB) begin
                        data_d  = shift_q[WIDTH-1];
                        shift_d = {shift_q[WIDTH-2:0], 1'b0};
                    end else begin
                        data_d  = shift_q[0];
                        shift_d = {1'b0, shift_q[WIDTH-1:1]};
                    end
                end else if (xfer_s) begin
                    load_s = 1'b1;
                end else if (IDLE_GAP > 0) begin
                    state_d = GAP;
                    gap_d   = {GAP_W{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                    gap_d   = {GAP_W{1'b0}};
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A load puts the first send-order bit straight onto the output register.
        if (load_s) begin
            state_d = SHIFT;
            cnt_d   = {CNT_W{1'b0}};
            valid_d = 1'b1;
            done_d  = 1'b0;
            if (SEND_MSB) begin
                data_d  = in_data[WIDTH-1];
                shift_d = {in_data[WIDTH-2:0], 1'b0};
            end else begin
                data_d  = in_data[0];
                shift_d = {1'b0, in_data[WIDTH-1:1]};
            end
        end else begin
            load_s = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            state_q <= IDLE;
            shift_q <= {WIDTH{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            gap_q   <= {GAP_W{1'b0}};
            data_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign data_out  = data_q;
    assign bit_valid = valid_q;
    assign word_done = done_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench: two serializer configurations driven from word queues and
// compared each cycle against a queue-of-bits reference model.
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       vld0, vld1;
    logic [7:0] dat0, dat1;
    logic       rdy0, rdy1, do0, do1, bv0, bv1, wd0, wd1, bz0, bz1;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_GAP(0)) u_ser0 (
        .clk(clk), .rst(rst), .in_data(dat0), .in_valid(vld0), .in_ready(rdy0),
        .data_out(do0), .bit_valid(bv0), .word_done(wd0), .busy(bz0)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .IDLE_GAP(2)) u_ser1 (
        .clk(clk), .rst(rst), .in_data(dat1), .in_valid(vld1), .in_ready(rdy1),
        .data_out(do1), .bit_valid(bv1), .word_done(wd1), .busy(bz1)
    );

    int total = 0;
    int bad   = 0;

    int gaps[2] = '{0, 2};
    bit msbs[2] = '{1'b1, 1'b0};

    // Reference model: bits still to send, what is on the outputs now, idle slots left.
    bit   m_pend[2][$];
    logic m_valid[2];
    logic m_data[2];
    logic m_done[2];
    int   m_gap[2];

    logic [7:0] wq[2][$];
    logic cur_rdy[2], cur_data[2], cur_valid[2], cur_done[2], cur_busy[2];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_ready(input int i, input logic r);
        if (!r) return 1'b0;
        if (!m_valid[i]) return (m_gap[i] == 0);
        return (m_pend[i].size() == 0) && (gaps[i] == 0);
    endfunction

    task automatic m_step(input int i, input logic r, input logic v, input logic [7:0] d);
        logic rd;
        rd = m_ready(i, r);
        if (!r) begin
            m_pend[i].delete();
            m_valid[i] = 1'b0; m_data[i] = 1'b0; m_done[i] = 1'b0; m_gap[i] = 0;
        end else if (v && rd) begin
            m_pend[i].delete();
            for (int k = 0; k < 8; k++) m_pend[i].push_back(msbs[i] ? d[7-k] : d[k]);
            m_data[i]  = m_pend[i].pop_front();
            m_valid[i] = 1'b1;
            m_done[i]  = 1'b0;
        end else if (m_pend[i].size() > 0) begin
            m_data[i]  = m_pend[i].pop_front();
            m_valid[i] = 1'b1;
            m_done[i]  = (m_pend[i].size() == 0);
        end else if (m_valid[i]) begin
            m_valid[i] = 1'b0; m_data[i] = 1'b0; m_done[i] = 1'b0;
            m_gap[i]   = gaps[i];
        end else if (m_gap[i] > 0) begin
            m_gap[i]--;
        end
    endtask

    // One clock: drive at the falling edge, check, then advance the model over the rising edge.
    task automatic run_cycle(input logic r);
        logic       v[2];
        logic [7:0] d[2];
        logic       xfer;
        for (int i = 0; i < 2; i++) begin
            v[i] = (wq[i].size() > 0);
            d[i] = v[i] ? wq[i][0] : 8'($urandom);
        end
        @(negedge clk);
        rst = r; vld0 = v[0]; dat0 = d[0]; vld1 = v[1]; dat1 = d[1];
        #1;
        cur_rdy   = '{rdy0, rdy1};
        cur_data  = '{do0, do1};
        cur_valid = '{bv0, bv1};
        cur_done  = '{wd0, wd1};
        cur_busy  = '{bz0, bz1};
        for (int i = 0; i < 2; i++) begin
            chk_eq($sformatf("in_ready%0d", i),  cur_rdy[i],   m_ready(i, r));
            chk_eq($sformatf("bit_valid%0d", i), cur_valid[i], m_valid[i]);
            chk_eq($sformatf("data_out%0d", i),  cur_data[i],  m_data[i]);
            chk_eq($sformatf("word_done%0d", i), cur_done[i],  m_done[i]);
            chk_eq($sformatf("busy%0d", i),      cur_busy[i],  m_valid[i] || (m_gap[i] > 0));
            xfer = v[i] && m_ready(i, r);
            m_step(i, r, v[i], d[i]);
            if (xfer) void'(wq[i].pop_front());
        end
    endtask

    initial begin
        logic [7:0]  cap8[2];
        logic [7:0]  dm8[2];
        logic [15:0] data16, valid16, done16;
        logic [23:0] valid24;
        int          done_cnt;

        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 1'b0; m_data[i] = 1'b0; m_done[i] = 1'b0; m_gap[i] = 0;
        end
        rst = 1'b0; vld0 = 1'b0; vld1 = 1'b0; dat0 = 8'h00; dat1 = 8'h00;

        // Reset held with a word offered: nothing may be taken.
        wq[0].push_back(8'hB5);
        wq[1].push_back(8'hB5);
        run_cycle(1'b0);
        run_cycle(1'b0);
        chk_eq("rst_ready", cur_rdy[0], 1'b0);
        chk_eq("rst_valid", cur_valid[0], 1'b0);
        run_cycle(1'b1);
        chk_eq("release_ready", cur_rdy[0], 1'b1);

        // Bit order for 8'hB5 in both directions, word_done on the last bit only.
        cap8 = '{8'h00, 8'h00};
        dm8  = '{8'h00, 8'h00};
        for (int k = 0; k < 9; k++) begin
            run_cycle(1'b1);
            for (int i = 0; i < 2; i++) begin
                if (k < 8) begin
                    cap8[i] = {cap8[i][6:0], cur_data[i]};
                    dm8[i]  = {dm8[i][6:0], cur_done[i]};
                end else begin
                    chk_eq($sformatf("b5_tail_valid%0d", i), cur_valid[i], 1'b0);
                end
            end
        end
        chk_eq("b5_msb_first", cap8[0], 8'hB5);
        chk_eq("b5_lsb_first", cap8[1], 8'hAD);
        chk_eq("b5_done_msb", dm8[0], 8'h01);
        chk_eq("b5_done_lsb", dm8[1], 8'h01);
        for (int k = 0; k < 4; k++) run_cycle(1'b1);

        // Back-to-back on instance 0, gapped words on instance 1.
        wq[0].push_back(8'hFF); wq[0].push_back(8'h00);
        wq[1].push_back(8'hA5); wq[1].push_back(8'h3C);
        run_cycle(1'b1);
        data16 = '0; valid16 = '0; done16 = '0; valid24 = '0;
        for (int k = 0; k < 24; k++) begin
            run_cycle(1'b1);
            if (k < 16) begin
                data16  = {data16[14:0], cur_data[0]};
                valid16 = {valid16[14:0], cur_valid[0]};
                done16  = {done16[14:0], cur_done[0]};
            end
            valid24 = {valid24[22:0], cur_valid[1]};
        end
        chk_eq("b2b_data", data16, 16'hFF00);
        chk_eq("b2b_valid", valid16, 16'hFFFF);
        chk_eq("b2b_done", done16, 16'h0101);
        // Two GAP slots plus the IDLE slot in which the queued word is accepted.
        chk_eq("gap_valid", valid24, 24'hFF1FE0);

        // Reset after bit 3 of a word: no word_done, clean restart afterwards.
        wq[0].push_back(8'hB5);
        run_cycle(1'b1);
        done_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            run_cycle(1'b1);
            done_cnt += int'(cur_done[0]);
        end
        run_cycle(1'b0);
        done_cnt += int'(cur_done[0]);
        for (int k = 0; k < 10; k++) begin
            run_cycle(1'b1);
            done_cnt += int'(cur_done[0]);
        end
        chk_eq("midword_no_done", done_cnt, 0);
        wq[0].push_back(8'hB5);
        run_cycle(1'b1);
        cap8[0] = 8'h00;
        for (int k = 0; k < 8; k++) begin
            run_cycle(1'b1);
            cap8[0] = {cap8[0][6:0], cur_data[0]};
        end
        chk_eq("after_reset_b5", cap8[0], 8'hB5);

        // Random traffic and occasional resets.
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < 2; i++) begin
                if ((wq[i].size() < 3) && ($urandom_range(3, 0) == 0))
                    wq[i].push_back(8'($urandom));
            end
            run_cycle(($urandom_range(99, 0) == 0) ? 1'b0 : 1'b1);
        end
        for (int c = 0; c < 60; c++) run_cycle(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
